// File: rtl/imm_decode_stage.sv
// RISC-V decode-stage immediate generator with pc+imm target.
// Opcode-driven format decode behind a 2-entry skid-buffered handshake.
module imm_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_I    = 3'b001;
  localparam logic [2:0] T_S    = 3'b010;
  localparam logic [2:0] T_B    = 3'b011;
  localparam logic [2:0] T_U    = 3'b100;
  localparam logic [2:0] T_J    = 3'b101;
  localparam logic [2:0] T_SH   = 3'b110;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic [2:0]      ty;
    logic            ill;
  } entry_t;

  entry_t dec_d;
  entry_t m_q, s_q;
  logic   m_valid_q, s_valid_q;
  logic   accept;

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic signed [11:0] i12, s12;
  logic signed [12:0] b13;
  logic signed [20:0] j21;
  logic signed [31:0] u32;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign i12 = instr[31:20];
  assign s12 = {instr[31:25], instr[11:7]};
  assign b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign u32 = {instr[31:12], 12'b0};

  always_comb begin
    dec_d = '0;
    unique case (opc)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_d.ty  = T_I;
        dec_d.imm = XLEN'(i12);
      end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // shamt width follows XLEN; funct7 never leaks in
          dec_d.ty  = T_SH;
          dec_d.imm = (XLEN == 64) ? XLEN'(instr[25:20])
                                   : XLEN'(instr[24:20]);
        end else begin
          dec_d.ty  = T_I;
          dec_d.imm = XLEN'(i12);
        end
      end
      7'b0100011: begin
        dec_d.ty  = T_S;
        dec_d.imm = XLEN'(s12);
      end
      7'b1100011: begin
        dec_d.ty  = T_B;
        dec_d.imm = XLEN'(b13);
      end
      7'b1101111: begin
        dec_d.ty  = T_J;
        dec_d.imm = XLEN'(j21);
      end
      7'b0110111, 7'b0010111: begin
        dec_d.ty  = T_U;
        dec_d.imm = XLEN'(u32);
      end
      7'b0110011: dec_d.ty = T_NONE;
      default:    dec_d.ill = 1'b1;
    endcase
    dec_d.tgt = pc + dec_d.imm;
  end

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && !s_valid_q && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
    end else if (flush) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else if (s_valid_q) begin
      if (out_ready) begin
        m_q       <= s_q;
        s_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!m_valid_q || out_ready) begin
        m_q       <= dec_d;
        m_valid_q <= 1'b1;
      end else begin
        s_q       <= dec_d;
        s_valid_q <= 1'b1;
      end
    end else if (out_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign out_valid = m_valid_q;
  assign immext    = m_q.imm;
  assign target    = m_q.tgt;
  assign imm_type  = m_q.ty;
  assign illegal   = m_q.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances in lockstep,
// checked against a queue model and spec-derived immediate arithmetic.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc64;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] immext32, target32;
  logic [2:0]  imm_type32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] immext64, target64;
  logic [2:0]  imm_type64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } txn_t;
  txn_t q[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .pc(pc64[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready),
    .immext(immext32), .imm_type(imm_type32),
    .target(target32), .illegal(illegal32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .pc(pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .immext(immext64), .imm_type(imm_type64),
    .target(target64), .illegal(illegal64)
  );

  function automatic longint sx(longint v, int bits);
    longint half, full;
    half = longint'(1) << (bits - 1);
    full = longint'(1) << bits;
    return (v >= half) ? v - full : v;
  endfunction

  function automatic logic [2:0] ref_type(logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h67, 7'h73: return 3'd1;
      7'h13: return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 3'd6 : 3'd1;
      7'h23: return 3'd2;
      7'h63: return 3'd3;
      7'h37, 7'h17: return 3'd4;
      7'h6F: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic ref_ill(logic [31:0] i);
    return ref_type(i) == 3'd0 && i[6:0] != 7'h33;
  endfunction

  function automatic logic [63:0] ref_imm(logic [31:0] i, int xlen);
    longint v;
    v = 0;
    case (ref_type(i))
      3'd1: v = sx(longint'(i[31:20]), 12);
      3'd6: v = longint'(i >> 20) % xlen;
      3'd2: v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
      3'd3: v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                   + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
      3'd5: v = sx(longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096
                   + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
      3'd4: v = sx(longint'(i[31:12]) * 4096, 32);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    txn_t        t;
    logic [63:0] e32, e64;
    chk("in_ready32", {63'b0, in_ready32}, {63'b0, q.size() < 2});
    chk("in_ready64", {63'b0, in_ready64}, {63'b0, q.size() < 2});
    chk("out_valid32", {63'b0, out_valid32}, {63'b0, q.size() > 0});
    chk("out_valid64", {63'b0, out_valid64}, {63'b0, q.size() > 0});
    if (q.size() > 0) begin
      t   = q[0];
      e32 = ref_imm(t.ins, 32);
      e64 = ref_imm(t.ins, 64);
      chk("imm32", {32'b0, immext32}, e32);
      chk("tgt32", {32'b0, target32}, {32'b0, t.pc[31:0] + e32[31:0]});
      chk("type32", {61'b0, imm_type32}, {61'b0, ref_type(t.ins)});
      chk("ill32", {63'b0, illegal32}, {63'b0, ref_ill(t.ins)});
      chk("imm64", immext64, e64);
      chk("tgt64", target64, t.pc + e64);
      chk("type64", {61'b0, imm_type64}, {61'b0, ref_type(t.ins)});
      chk("ill64", {63'b0, illegal64}, {63'b0, ref_ill(t.ins)});
    end
  endtask

  // One clock: apply inputs, check at negedge, advance model at posedge.
  task automatic cycle(logic v, logic [31:0] ins, logic [63:0] p,
                       logic ordy, logic fl, logic rst);
    logic acc;
    txn_t t;
    in_valid  = v;
    instr     = ins;
    pc64      = p;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
    check_state();
    if (rst || fl) begin
      q.delete();
    end else begin
      acc = v && (q.size() < 2);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) begin
        t.ins = ins;
        t.pc  = p;
        q.push_back(t);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [10] = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h23,
                           7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};

  initial begin
    logic [31:0] ri;
    logic [63:0] rp;
    int          k;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc64 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_imm32", {32'b0, immext32}, 64'h0);
    chk("rst_tgt32", {32'b0, target32}, 64'h0);
    chk("rst_type32", {61'b0, imm_type32}, 64'h0);
    chk("rst_imm64", immext64, 64'h0);
    chk("rst_vld", {62'b0, out_valid32, out_valid64}, 64'h0);
    chk("rst_rdy", {62'b0, in_ready32, in_ready64}, 64'h3);

    cycle(1, 32'hFFF00093, 64'h0, 1, 0, 0);
    chk("addi_imm", {32'b0, immext32}, 64'hFFFF_FFFF);
    chk("addi_tgt", {32'b0, target32}, 64'hFFFF_FFFF);
    chk("addi_type", {61'b0, imm_type32}, 64'd1);
    cycle(1, 32'h4020D093, 64'h0, 1, 0, 0);
    chk("srai_imm", {32'b0, immext32}, 64'h2);
    chk("srai_type", {61'b0, imm_type32}, 64'd6);
    cycle(1, 32'hFE000EE3, 64'h100, 1, 0, 0);
    chk("beq_imm", {32'b0, immext32}, 64'hFFFF_FFFC);
    chk("beq_tgt", {32'b0, target32}, 64'hFC);
    chk("beq_type", {61'b0, imm_type32}, 64'd3);
    cycle(1, 32'h00112623, 64'h0, 1, 0, 0);
    chk("sw_imm", {32'b0, immext32}, 64'hC);
    chk("sw_type", {61'b0, imm_type32}, 64'd2);
    cycle(1, 32'h800002B7, 64'h0, 1, 0, 0);
    chk("lui_imm32", {32'b0, immext32}, 64'h8000_0000);
    chk("lui_imm64", immext64, 64'hFFFF_FFFF_8000_0000);
    cycle(1, 32'h0000007F, 64'h40, 1, 0, 0);
    chk("ill_flag", {63'b0, illegal32}, 64'h1);
    chk("ill_imm", {32'b0, immext32}, 64'h0);
    cycle(0, 32'h0, 64'h0, 1, 0, 0);

    // back-pressure: A, B accepted, C held until out_ready rises
    cycle(1, 32'h00100093, 64'h200, 0, 0, 0);
    cycle(1, 32'h00200113, 64'h204, 0, 0, 0);
    cycle(1, 32'h00300193, 64'h208, 0, 0, 0);
    chk("bp_full", {63'b0, in_ready32}, 64'h0);
    cycle(1, 32'h00300193, 64'h208, 0, 0, 0);
    cycle(1, 32'h00300193, 64'h208, 1, 0, 0);
    cycle(0, 32'h0, 64'h0, 1, 0, 0);
    cycle(0, 32'h0, 64'h0, 1, 0, 0);
    cycle(0, 32'h0, 64'h0, 1, 0, 0);

    // flush with both entries full, flush beats a concurrent offer
    cycle(1, 32'h00500293, 64'h300, 0, 0, 0);
    cycle(1, 32'h00600313, 64'h304, 0, 0, 0);
    cycle(1, 32'h00700393, 64'h308, 0, 1, 0);
    chk("fl_vld", {63'b0, out_valid32}, 64'h0);
    chk("fl_rdy", {63'b0, in_ready32}, 64'h1);
    cycle(0, 32'h0, 64'h0, 1, 0, 0);
    cycle(0, 32'h0, 64'h0, 1, 0, 0);

    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 10);
      ri = $urandom;
      ri[6:0] = (k == 10) ? 7'($urandom) : ops[k];
      rp = {32'($urandom), 32'($urandom)};
      cycle($urandom_range(0, 3) != 0, ri, rp,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) == 0);
    end
    cycle(0, 32'h0, 64'h0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
